// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared constants and types for the BCD converter arbiter: FSM encoding,
// digit width and default operand width.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int N_DEFAULT = 9;

  // Sequencer states, 2-bit legacy-compatible encoding
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_FIN = 2'd2;
  localparam logic [1:0] S_DELIVER  = 2'd3;

  typedef struct packed {
    logic [DIGIT_W-1:0] c;
    logic [DIGIT_W-1:0] d;
    logic [DIGIT_W-1:0] u;
  } bcd_digits_t;

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the shared BCD converter arbiter.
interface bcd_conv_arbiter_if
  import bcd_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int R = 4
);

  // Handshake: req[i] is a level held high with a stable operand in
  // req_bin[i*N +: N] until done[i] pulses for one cycle; err and res_* are
  // valid with that pulse and hold until the next one. req[i] still high in
  // the cycle after done[i] is a fresh request.
  logic [R-1:0]       req;
  logic [R*N-1:0]     req_bin;
  logic [R-1:0]       done;
  logic               err;
  logic [DIGIT_W-1:0] res_c;
  logic [DIGIT_W-1:0] res_d;
  logic [DIGIT_W-1:0] res_u;
  logic               busy;

  modport master (
    output req, req_bin,
    input  done, err, res_c, res_d, res_u, busy
  );

  modport slave (
    input  req, req_bin,
    output done, err, res_c, res_d, res_u, busy
  );

endinterface

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo R.
module rr_pick #(
  parameter int R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(R)-1:0] idx
);

  localparam int IW = $clog2(R);

  int j;

  // Scan from the farthest candidate back to ptr so the nearest one wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = R - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= R) j = j - R;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one binary-to-BCD converter among R
// requesters, with a watchdog on the converter's end-of-conversion strobe.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int R    = 4,
  parameter int WDOG = 2*N+8
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_conv_arbiter_if.slave    bus,
  output logic                 conv_start,
  output logic [N-1:0]         conv_in,
  input  logic                 conv_listo,
  input  logic                 conv_fin,
  input  logic [DIGIT_W-1:0]   conv_c,
  input  logic [DIGIT_W-1:0]   conv_d,
  input  logic [DIGIT_W-1:0]   conv_u,
  output logic [1:0]           dbg_state,
  output logic [$clog2(R)-1:0] dbg_ptr
);

  localparam int IW = $clog2(R);
  localparam int WW = $clog2(WDOG+1);

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [WW-1:0] wd;
  logic          wd_expire;
  bcd_digits_t   res;
  logic          err_q;
  logic [R-1:0]  done_q;

  function automatic logic [R-1:0] grant_onehot(input logic [IW-1:0] g);
    logic [R-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  rr_pick #(.R(R)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Expiry fires in the last allowed WAIT_FIN cycle so done lands WDOG
  // cycles after entry; conv_fin in that same cycle takes priority.
  assign wd_expire  = (wd == WW'(WDOG-1));
  assign conv_start = (state == S_ISSUE) && conv_listo;

  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.res_c = res.c;
  assign bus.res_d = res.d;
  assign bus.res_u = res.u;

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= '0;
      gnt     <= '0;
      wd      <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      res     <= '0;
      conv_in <= '0;
    end else begin
      done_q <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            gnt     <= pick_idx;
            conv_in <= bus.req_bin[pick_idx*N +: N];
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (conv_listo) begin
            wd    <= '0;
            state <= S_WAIT_FIN;
          end
        end
        S_WAIT_FIN: begin
          if (conv_fin) begin
            res    <= '{c: conv_c, d: conv_d, u: conv_u};
            err_q  <= 1'b0;
            done_q <= grant_onehot(gnt);
            state  <= S_DELIVER;
          end else if (wd_expire) begin
            res    <= '0;
            err_q  <= 1'b1;
            done_q <= grant_onehot(gnt);
            state  <= S_DELIVER;
          end else if (wd != WW'(WDOG)) begin
            wd <= wd + 1'b1;
          end
        end
        S_DELIVER: begin
          ptr   <= (gnt == IW'(R-1)) ? '0 : gnt + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed and randomized bench for bcd_conv_arbiter with a behavioural
// converter model and a round-robin/arithmetic reference model.
module tb_bcd_conv_arbiter;
  import bcd_pkg::*;

  localparam int N    = 9;
  localparam int R    = 4;
  localparam int WDOG = 2*N+8;
  localparam int LAT  = 2*N+2;
  localparam int EW   = R+1+3*DIGIT_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_start = 0;
  int checks = 0;
  int errors = 0;

  logic [R-1:0]   req_v;
  logic [N-1:0]   ops [R];
  logic [R*N-1:0] req_bin_v;
  int             model_ptr;
  logic [EW-1:0]  exp_q[$];

  logic               conv_start, conv_listo, conv_fin;
  logic               listo_en, conv_abort, conv_active;
  logic [N-1:0]       conv_in, conv_opnd;
  logic [DIGIT_W-1:0] conv_c, conv_d, conv_u;
  int                 conv_lat, conv_cnt;
  logic [1:0]         dbg_state;
  logic [1:0]         dbg_ptr;

  bcd_conv_arbiter_if #(.N(N), .R(R)) bus ();

  assign bus.req = req_v;
  assign bus.req_bin = req_bin_v;
  always_comb begin
    req_bin_v = '0;
    for (int i = 0; i < R; i++) req_bin_v[i*N +: N] = ops[i];
  end

  bcd_conv_arbiter #(.N(N), .R(R), .WDOG(WDOG)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .conv_start (conv_start),
    .conv_in    (conv_in),
    .conv_listo (conv_listo),
    .conv_fin   (conv_fin),
    .conv_c     (conv_c),
    .conv_d     (conv_d),
    .conv_u     (conv_u),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (conv_start) n_start <= n_start + 1;
  end

  // Converter model: fin arrives conv_lat cycles after the start cycle;
  // conv_lat == 0 models a hung converter.
  assign conv_listo = listo_en & ~conv_active;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_active <= 1'b0;
      conv_cnt    <= 0;
      conv_fin    <= 1'b0;
      conv_opnd   <= '0;
      {conv_c, conv_d, conv_u} <= 12'hAAA;
    end else if (conv_abort) begin
      conv_active <= 1'b0;
      conv_fin    <= 1'b0;
    end else begin
      conv_fin <= 1'b0;
      {conv_c, conv_d, conv_u} <= 12'hAAA;
      if (conv_start) begin
        conv_active <= 1'b1;
        conv_cnt    <= 1;
        conv_opnd   <= conv_in;
      end else if (conv_active) begin
        conv_cnt <= conv_cnt + 1;
        if (conv_fin) begin
          conv_active <= 1'b0;
        end else if (conv_lat != 0 && conv_cnt + 1 == conv_lat) begin
          conv_fin <= 1'b1;
          conv_c   <= 4'(int'(conv_opnd) / 100);
          conv_d   <= 4'((int'(conv_opnd) / 10) % 10);
          conv_u   <= 4'(int'(conv_opnd) % 10);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [R-1:0] m, input int p);
    for (int k = 0; k < R; k++) if (m[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  function automatic logic [EW-1:0] exp_word(input int idx, input bit e);
    int v;
    logic [R-1:0] oh;
    v = int'(ops[idx]);
    oh = '0;
    oh[idx] = 1'b1;
    if (e) return {oh, 1'b1, 12'd0};
    return {oh, 1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_v = '0;
    tick(2);
    rst = 1'b1;
    model_ptr = 0;
  endtask

  task automatic wait_done(output bit found, output int dcyc);
    int k;
    found = 1'b0;
    dcyc = -1;
    k = 0;
    while (!found && k < 400) begin
      @(negedge clk);
      k++;
      if (bus.done != '0) begin
        found = 1'b1;
        dcyc = cyc;
      end
    end
  endtask

  // Serve every raised request; each done is scored against the model.
  task automatic serve(input string tag, input int extra, input int reraise_idx,
                       input bit gap_chk, input bit exp_err,
                       output int first_cyc, output int last_cyc);
    int left, prev, idx, guard, dcyc;
    bit found, reraised;
    logic [EW-1:0] obs;
    left = extra; prev = -1; first_cyc = -1; last_cyc = -1; guard = 0; reraised = 0;
    while (req_v != '0 && guard < 32) begin
      guard++;
      idx = pick(req_v, model_ptr);
      exp_q.push_back(exp_word(idx, exp_err));
      wait_done(found, dcyc);
      check({tag, "_timeout"}, 32'(found), 32'd1);
      if (!found) begin
        exp_q.delete();
        return;
      end
      obs = {bus.done, bus.err, bus.res_c, bus.res_d, bus.res_u};
      check({tag, "_result"}, 32'(obs), 32'(exp_q.pop_front()));
      if (gap_chk && prev >= 0) check({tag, "_gap"}, dcyc - prev, 2*N+5);
      if (first_cyc < 0) first_cyc = dcyc;
      prev = dcyc;
      last_cyc = dcyc;
      model_ptr = (idx + 1) % R;
      if (idx == reraise_idx && !reraised) begin
        reraised = 1'b1;
        ops[idx] = N'($urandom_range(0, (1 << N) - 1));
      end else if (left > 0 && $urandom_range(0, 1) == 1) begin
        left--;
        ops[idx] = N'($urandom_range(0, (1 << N) - 1));
      end else begin
        req_v[idx] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t, f, l, s0;
    bit nd;
    logic [R-1:0] mask;
    req_v = '0;
    for (int i = 0; i < R; i++) ops[i] = '0;
    listo_en = 1'b1;
    conv_abort = 1'b0;
    conv_lat = LAT;
    model_ptr = 0;

    // reset values
    #1 rst = 1'b0;
    #2;
    check("rst_outs", 32'({bus.done, bus.err, bus.res_c, bus.res_d, bus.res_u, bus.busy, conv_start}), 32'd0);
    check("rst_conv_in", 32'(conv_in), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    tick(2);
    rst = 1'b1;

    // single request, operand 317
    ops[2] = 9'd317;
    req_v[2] = 1'b1;
    t = cyc;
    s0 = n_start;
    tick(1);
    check("t1_issue_start", 32'({conv_start, bus.busy}), 32'b11);
    tick(4);
    check("t1_conv_in", 32'(conv_in), 32'd317);
    serve("t1", 0, -1, 1'b0, 1'b0, f, l);
    check("t1_latency", l - t, 22);
    check("t1_starts", n_start - s0, 1);
    tick(1);
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_res_hold", 32'({bus.res_c, bus.res_d, bus.res_u}), 32'h317);

    // all four simultaneously, req[0] re-raised at once
    do_reset();
    ops[0] = 9'd0; ops[1] = 9'd255; ops[2] = 9'd511; ops[3] = 9'd100;
    req_v = 4'hF;
    t = cyc;
    serve("t2", 0, 0, 1'b1, 1'b0, f, l);
    check("t2_first", f - t, 22);
    check("t2_last", l - t, 22 + 4*(2*N+5));

    // converter not ready for 10 cycles after the grant
    tick(1);
    listo_en = 1'b0;
    ops[1] = N'($urandom_range(0, 511));
    req_v[1] = 1'b1;
    t = cyc;
    s0 = n_start;
    nd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (conv_start !== 1'b0 || bus.busy !== 1'b1) nd = 1'b1;
    end
    check("t3_issue_hold", 32'(nd), 32'd0);
    tick(1);
    listo_en = 1'b1;
    #1;
    check("t3_start_follows", 32'(conv_start), 32'd1);
    serve("t3", 0, -1, 1'b0, 1'b0, f, l);
    check("t3_latency", l - t, 32);
    check("t3_starts", n_start - s0, 1);

    // converter hang, then normal recovery
    tick(1);
    conv_lat = 0;
    ops[3] = N'($urandom_range(1, 511));
    req_v[3] = 1'b1;
    t = cyc;
    serve("t4", 0, -1, 1'b0, 1'b1, f, l);
    check("t4_wdog", l - t, 2 + WDOG);
    conv_abort = 1'b1;
    tick(1);
    conv_abort = 1'b0;
    conv_lat = LAT;
    ops[0] = N'($urandom_range(1, 511));
    req_v[0] = 1'b1;
    t = cyc;
    serve("t4_next", 0, -1, 1'b0, 1'b0, f, l);
    check("t4_next_latency", l - t, 22);

    // fin coincident with watchdog expiry, then one cycle too late
    tick(1);
    conv_lat = WDOG;
    ops[2] = N'($urandom_range(1, 511));
    req_v[2] = 1'b1;
    t = cyc;
    serve("t5_coinc", 0, -1, 1'b0, 1'b0, f, l);
    check("t5_coinc_latency", l - t, 2 + WDOG);
    tick(1);
    conv_lat = WDOG + 1;
    ops[1] = N'($urandom_range(1, 511));
    req_v[1] = 1'b1;
    t = cyc;
    serve("t5_late", 0, -1, 1'b0, 1'b1, f, l);
    check("t5_late_latency", l - t, 2 + WDOG);
    tick(2);

    // randomized request sets
    for (int r = 0; r < 6; r++) begin
      tick(1);
      conv_lat = $urandom_range(LAT, LAT + 4);
      mask = R'($urandom_range(1, (1 << R) - 1));
      for (int i = 0; i < R; i++) if (mask[i]) ops[i] = N'($urandom_range(0, 511));
      req_v = mask;
      serve("rnd", 2, -1, 1'b0, 1'b0, f, l);
    end

    // reset mid-conversion
    tick(1);
    conv_lat = LAT;
    ops[2] = N'($urandom_range(1, 511));
    req_v[2] = 1'b1;
    tick(8);
    check("t6_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_outs", 32'({bus.done, bus.err, bus.res_c, bus.res_d, bus.res_u, bus.busy, conv_start}), 32'd0);
    check("t6_rst_conv_in", 32'(conv_in), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(S_IDLE));
    req_v = '0;
    nd = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done != '0) nd = 1'b1;
    end
    check("t6_no_done", 32'(nd), 32'd0);
    rst = 1'b1;
    model_ptr = 0;
    check("t6_ptr_after", 32'(dbg_ptr), 32'd0);
    ops[1] = N'($urandom_range(0, 511));
    ops[3] = N'($urandom_range(0, 511));
    req_v = 4'b1010;
    t = cyc;
    serve("t6_after", 0, -1, 1'b1, 1'b0, f, l);
    check("t6_after_latency", f - t, 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-BCD converter among R requesters. It grants one requester at a time, latches that requester's binary operand and drives the converter's start/operand inputs. It then waits for the converter's end-of-conversion strobe and returns the three BCD digits to the granted requester with a one-cycle done pulse. It sits between the requesting blocks (display drivers, serial formatters) and the single shared converter instance.

## Interface
- N, 9: operand width; legal range 1..9, so the result always fits in three digits.
- R, 4: number of requesters; legal range 2..8.
- WDOG, 2*N+8: cycles allowed in WAIT_FIN before timeout.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  R  request per requester; level, held until its done
- req_bin  in  R*N  operands; requester i uses bits [i*N +: N]
- done  out  R  one-hot, one-cycle pulse: result for requester i is valid
- err  out  1  valid with done; 1 = converter timeout, digits forced to 0
- res_c, res_d, res_u  out  4 each  hundreds/tens/units digits, valid with done, held until the next done
- busy  out  1  high in every state except IDLE
- conv_start  out  1  to the converter's start input
- conv_in  out  N  to the converter's operand input
- conv_listo  in  1  converter idle
- conv_fin  in  1  converter last-cycle strobe; digits valid during this cycle
- conv_c, conv_d, conv_u  in  4 each  converter digit outputs

## Operation
- FSM states: IDLE, ISSUE, WAIT_FIN, DELIVER.
- IDLE:
  - If any req is set, pick the first set bit searching upward from ptr, wrapping modulo R.
  - Latch the chosen index into gnt and its operand into conv_in, then go to ISSUE.
- ISSUE:
  - conv_start = conv_listo.
  - If conv_listo is high, go to WAIT_FIN; otherwise stay in ISSUE. There is no timeout in ISSUE.
- WAIT_FIN:
  - conv_in is held stable.
  - On conv_fin, capture conv_c/d/u into res_* with err=0, then go to DELIVER.
  - If the watchdog counter reaches WDOG first, set res_*=0 and err=1, then go to DELIVER.
- DELIVER:
  - done[gnt]=1 for exactly one cycle.
  - ptr <= (gnt+1) mod R, then go to IDLE.
- Requester rule:
  - req[i] stays high, with a stable operand, until done[i].
  - If req[i] is still high in the cycle after done[i], that is a new request.
  - Lowering req before done is illegal. The arbiter ignores it and delivers anyway.
- Requests that arrive while busy wait. There is no preemption.
- Fairness: every requester is served within R grants.
- Watchdog counter: width $clog2(WDOG+1). It clears on entry to WAIT_FIN and saturates.

## Timing
- Reset values:
  - state=IDLE, ptr=0, gnt=0.
  - done=0, err=0, res_*=0, busy=0.
  - conv_start=0, conv_in=0.
- Registered outputs: done, err, res_*, conv_in. Combinational outputs: conv_start, busy.
- Converter idle, request seen in IDLE at cycle t:
  - ISSUE at t+1, with conv_start high.
  - conv_fin at t+3+2N.
  - done at t+4+2N. Latency is 2N+4 cycles; 22 cycles for N=9.
- Back-to-back grants: from DELIVER, next IDLE evaluation is one cycle later. Minimum period is 2N+5 cycles per conversion.
- If conv_fin and the watchdog expiry fall in the same cycle, conv_fin wins (err=0).
- Reset asserted mid-operation:
  - All state returns to reset values immediately, with no done pulse.
  - The converter is reset by its own reset path and is not the arbiter's responsibility.

## Structure
- Shared package bcd_pkg holds:
  - the FSM state encoding (2 bits);
  - the digit-width constant (4);
  - the default operand width (9).
- One sub-module, rr_pick:
  - combinational round-robin priority pick;
  - inputs req[R] and ptr; outputs found and idx.
- Everything else lives in the top: FSM, watchdog, operand mux, result registers.

## Test plan
- Single request, N=9, R=4:
  - req[2]=1, operand 9'd317.
  - Expect done[2] 22 cycles later with res=3/1/7, err=0, and exactly one conv_start cycle.
- All four requesters, operands 0, 255, 511, 100, requested simultaneously, ptr=0:
  - Expect done order 0,1,2,3, each with the correct digits, e.g. 5/1/1 for 511.
  - Re-raising req[0] at once is served after requester 3.
- Converter not ready:
  - Hold conv_listo=0 for 10 cycles after the grant.
  - Expect ISSUE to hold, conv_start to follow conv_listo, and done to arrive 10 cycles later than nominal.
- Converter hang:
  - conv_fin never asserts.
  - Expect done with err=1 and res=0/0/0 exactly WDOG cycles after entering WAIT_FIN.
  - The next request then completes normally.
- Reset mid-conversion:
  - Drop rst while in WAIT_FIN.
  - Expect all outputs at reset values asynchronously, no done pulse, and ptr=0 after release.
- Coincident events:
  - conv_fin in the same cycle as the watchdog expiry: expect err=0 with the captured digits.
